uart_rx_unit: RTL

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: synchronized rx line, mid-bit sampling with a per-frame latched
// prescaler, and sticky overrun/frame-error flags cleared by a level acknowledge.
module uart_rx_unit #(
  parameter int PRESC_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PRESC_W-1:0] prescaler_i,
  input  logic               rx_pin_i,
  input  logic               rx_ack_i,
  output logic [7:0]         data_o,
  output logic               data_valid_o,
  output logic               overrun_o,
  output logic               frame_error_o,
  output logic               rx_busy_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rxs, rxs_prev_q;
  logic [PRESC_W-1:0]   p_q, p_d, cnt_q, cnt_d;
  logic [PRESC_W-1:0]   presc_clamped, half_m1, p_m1;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic                 capture, ferr_evt;

  assign rxs           = sync_q[SYNC_STAGES-1];
  assign presc_clamped = (prescaler_i < PRESC_W'(4)) ? PRESC_W'(4) : prescaler_i;
  assign half_m1       = (p_q >> 1) - PRESC_W'(1);
  assign p_m1          = p_q - PRESC_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      p_q        <= PRESC_W'(4);
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_pin_i};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cnt_d     = cnt_q + PRESC_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    capture   = 1'b0;
    ferr_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only a fresh high-to-low edge starts a frame; a line stuck low stays ignored.
        if (rxs_prev_q && !rxs) begin
          p_d     = presc_clamped;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (!rxs) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == p_m1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == p_m1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) capture = 1'b1;
          else     ferr_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // data_valid/rx_ack: a captured byte raises data_valid and it stays high until a cycle
  // with rx_ack high and no new capture; set events always win over the acknowledge.
  always_comb begin
    data_d  = capture ? shift_q : data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    if (capture)        valid_d = 1'b1;
    else if (rx_ack_i)  valid_d = 1'b0;
    if (capture && !rx_ack_i) ovr_d = ovr_q | valid_q;
    else if (rx_ack_i)        ovr_d = 1'b0;
    if (ferr_evt)       ferr_d = 1'b1;
    else if (rx_ack_i)  ferr_d = 1'b0;
  end

  assign data_o        = data_q;
  assign data_valid_o  = valid_q;
  assign overrun_o     = ovr_q;
  assign frame_error_o = ferr_q;
  assign rx_busy_o     = (state_q != IDLE);
  assign state_o       = state_q;

endmodule
